// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port synchronous RAM between the CPU (default
// owner) and an external loader. Loader bursts freeze the CPU through cpu_hold;
// the CPU read that was in flight when the hold began is replayed on resume.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_data_out,
    input  logic                  cpu_we,
    input  logic                  cpu_ioreq,
    output logic [DATA_WIDTH-1:0] cpu_data_in,
    output logic                  cpu_hold,
    input  logic                  ldr_req,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    input  logic                  ldr_we,
    output logic                  ldr_ack,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_req,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  ldr_grant
);

    typedef enum logic [2:0] {
        StCpu,
        StDrain,
        StGrant,
        StAck,
        StNext
    } state_t;

    localparam logic [3:0] BurstMax = 4'(MAX_BURST);

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_burst_cnt;
    logic                  r_replay_flag;
    logic [DATA_WIDTH-1:0] r_replay;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StCpu;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Burst counter and CPU read-data replay bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst_cnt   <= '0;
            r_replay_flag <= 1'b0;
            r_replay      <= '0;
        end else begin
            if (r_state == StCpu) begin
                r_burst_cnt <= '0;
            end else if (r_state == StAck) begin
                r_burst_cnt <= r_burst_cnt + 4'd1;
            end
            // In DRAIN the RAM output still holds the CPU read from the last CPU cycle.
            if (r_state == StDrain) begin
                r_replay <= mem_rdata;
            end
            if (r_state == StNext && w_state_next == StCpu) begin
                r_replay_flag <= 1'b1;
            end else if (r_state == StCpu) begin
                r_replay_flag <= 1'b0;
            end
        end
    end

    // Next-state logic; CPU gets at least one cycle between bursts.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StCpu:   if (ldr_req) w_state_next = StDrain;
            StDrain: w_state_next = StGrant;
            StGrant: w_state_next = StAck;
            StAck:   w_state_next = StNext;
            StNext: begin
                if (ldr_req && (r_burst_cnt < BurstMax)) begin
                    w_state_next = StGrant;
                end else begin
                    w_state_next = StCpu;
                end
            end
            default: w_state_next = StCpu;
        endcase
    end

    // RAM port steering: CPU in StCpu, loader only in StGrant, idle otherwise.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_data_out;
        mem_we    = 1'b0;
        mem_req   = 1'b0;
        case (r_state)
            StCpu: begin
                mem_we  = cpu_we & ~cpu_ioreq;
                mem_req = ~cpu_ioreq;
            end
            StGrant: begin
                mem_addr  = ldr_addr;
                mem_wdata = ldr_wdata;
                mem_we    = ldr_we;
                mem_req   = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_hold    = (r_state != StCpu);
    assign ldr_grant   = (r_state != StCpu);
    assign ldr_ack     = (r_state == StAck);
    // RAM output register holds the GRANT read through ACK (no access in ACK).
    assign ldr_rdata   = ldr_ack ? mem_rdata : '0;
    assign cpu_data_in = r_replay_flag ? r_replay : mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with a RAM model; loader acks are checked by
// a scoreboard monitor, CPU-side behaviour by inline checks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_we;
    logic        cpu_ioreq;
    logic [7:0]  cpu_data_in;
    logic        cpu_hold;
    logic        ldr_req;
    logic [11:0] ldr_addr;
    logic [7:0]  ldr_wdata;
    logic        ldr_we;
    logic        ldr_ack;
    logic [7:0]  ldr_rdata;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic [7:0]  mem_rdata;
    logic        ldr_grant;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [7:0]  data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [11:0] a;
        logic [7:0]  d;
        logic        we;
        logic        io;
        logic        exp_we;
        logic        exp_req;
    } vec_t;
    vec_t vecs[4];

    logic [7:0] ram [0:4095];

    mem_arbiter #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(8),
        .MAX_BURST (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_addr    (cpu_addr),
        .cpu_data_out(cpu_data_out),
        .cpu_we      (cpu_we),
        .cpu_ioreq   (cpu_ioreq),
        .cpu_data_in (cpu_data_in),
        .cpu_hold    (cpu_hold),
        .ldr_req     (ldr_req),
        .ldr_addr    (ldr_addr),
        .ldr_wdata   (ldr_wdata),
        .ldr_we      (ldr_we),
        .ldr_ack     (ldr_ack),
        .ldr_rdata   (ldr_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_req     (mem_req),
        .mem_rdata   (mem_rdata),
        .ldr_grant   (ldr_grant)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, 1-cycle read latency, output holds when idle.
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every ack consumes one expected transaction.
    always @(negedge clk) begin
        if (!reset && ldr_ack) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack expected none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.we) check("ldr_write_ram", 32'(ram[e.addr]), 32'(e.data));
                else      check("ldr_rdata", 32'(ldr_rdata), 32'(e.data));
            end
        end
    end

    // One loader transaction from the CPU state; returns at the first CPU cycle.
    task automatic ldr_txn(input logic we, input logic [11:0] a, input logic [7:0] d,
                           input logic [7:0] exp, output int lat);
        exp_t e;
        e.we = we; e.addr = a; e.data = exp;
        sb.push_back(e);
        ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_req = 1'b1;
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            lat++;
            if (ldr_ack) break;
        end
        if (!ldr_ack) check("ack_timeout", 32'(ldr_ack), 32'd1);
        ldr_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int lat;
        int acks;
        int free_cyc;

        reset = 1'b1;
        cpu_addr = '0; cpu_data_out = '0; cpu_we = 1'b0; cpu_ioreq = 1'b0;
        ldr_req = 1'b0; ldr_addr = '0; ldr_wdata = '0; ldr_we = 1'b0;
        #2;
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_ldr_ack", 32'(ldr_ack), 32'd0);
        check("rst_ldr_rdata", 32'(ldr_rdata), 32'd0);
        check("rst_ldr_grant", 32'(ldr_grant), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Idle: mem_* follows cpu_*; also preloads RAM through the CPU path.
        vecs[0] = '{12'h010, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{12'h020, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{12'h200, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{12'h0AB, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        foreach (vecs[i]) begin
            cpu_addr = vecs[i].a; cpu_data_out = vecs[i].d;
            cpu_we = vecs[i].we; cpu_ioreq = vecs[i].io;
            #1;
            check("idle_mem_addr", 32'(mem_addr), 32'(vecs[i].a));
            check("idle_mem_wdata", 32'(mem_wdata), 32'(vecs[i].d));
            check("idle_mem_we", 32'(mem_we), 32'(vecs[i].exp_we));
            check("idle_mem_req", 32'(mem_req), 32'(vecs[i].exp_req));
            check("idle_cpu_hold", 32'(cpu_hold), 32'd0);
            tick();
        end

        // Loader write 0xA5 -> 0x123, stepped cycle by cycle.
        cpu_addr = 12'h020; cpu_we = 1'b0; cpu_ioreq = 1'b0;
        sb.push_back('{1'b1, 12'h123, 8'hA5});
        ldr_we = 1'b1; ldr_addr = 12'h123; ldr_wdata = 8'hA5; ldr_req = 1'b1;
        tick();
        check("drain_hold", 32'(cpu_hold), 32'd1);
        check("drain_mem_req", 32'(mem_req), 32'd0);
        check("drain_grant", 32'(ldr_grant), 32'd1);
        tick();
        check("grant_mem_we", 32'(mem_we), 32'd1);
        check("grant_mem_addr", 32'(mem_addr), 32'h123);
        check("grant_mem_wdata", 32'(mem_wdata), 32'hA5);
        check("grant_ack_low", 32'(ldr_ack), 32'd0);
        tick();
        check("ack_pulse", 32'(ldr_ack), 32'd1);
        check("ack_mem_we", 32'(mem_we), 32'd0);
        ldr_req = 1'b0;
        tick();
        check("next_hold", 32'(cpu_hold), 32'd1);
        check("next_ack_low", 32'(ldr_ack), 32'd0);
        tick();
        check("resume_hold", 32'(cpu_hold), 32'd0);
        cpu_addr = 12'h123;
        tick();
        check("cpu_read_123", 32'(cpu_data_in), 32'hA5);

        // Loader read with replay of the interrupted CPU read of 0x020.
        cpu_addr = 12'h020;
        ldr_txn(1'b0, 12'h010, 8'h00, 8'h3C, lat);
        check("read_latency", 32'(lat), 32'd3);
        check("replay_hold", 32'(cpu_hold), 32'd0);
        check("replay_data", 32'(cpu_data_in), 32'h77);

        // Burst fairness: six writes with ldr_req held.
        cpu_addr = 12'h010;
        for (int i = 0; i < 6; i++) sb.push_back('{1'b1, 12'h300 + 12'(i), 8'h40 + 8'(i)});
        ldr_we = 1'b1; ldr_addr = 12'h300; ldr_wdata = 8'h40; ldr_req = 1'b1;
        acks = 0;
        free_cyc = 0;
        for (int c = 0; c < 80 && acks < 6; c++) begin
            tick();
            if (ldr_ack) begin
                acks++;
                if (acks < 6) begin
                    ldr_addr = 12'h300 + 12'(acks);
                    ldr_wdata = 8'h40 + 8'(acks);
                end else begin
                    ldr_req = 1'b0;
                end
            end else if (acks == 4 && !cpu_hold) begin
                free_cyc++;
            end
        end
        tick();
        tick();
        check("burst_acks", 32'(acks), 32'd6);
        check("burst_cpu_gap", 32'(free_cyc), 32'd1);
        check("burst_end_hold", 32'(cpu_hold), 32'd0);

        // Reset during GRANT abandons the write to 0x200.
        cpu_addr = 12'h200;
        ldr_we = 1'b1; ldr_addr = 12'h200; ldr_wdata = 8'h5A; ldr_req = 1'b1;
        tick();
        tick();
        check("rst_grant_we", 32'(mem_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_hold", 32'(cpu_hold), 32'd0);
        check("rst_async_grant", 32'(ldr_grant), 32'd0);
        check("rst_async_ack", 32'(ldr_ack), 32'd0);
        check("rst_async_mem_we", 32'(mem_we), 32'd0);
        ldr_req = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        tick();
        tick();
        check("rst_no_write", 32'(cpu_data_in), 32'h11);

        // ioreq cycle never touches RAM; loader still proceeds.
        cpu_addr = 12'h300; cpu_data_out = 8'hEE; cpu_we = 1'b1; cpu_ioreq = 1'b1;
        #1;
        check("io_mem_we", 32'(mem_we), 32'd0);
        check("io_mem_req", 32'(mem_req), 32'd0);
        ldr_txn(1'b0, 12'h300, 8'h00, 8'h40, lat);
        check("io_ldr_latency", 32'(lat), 32'd3);
        cpu_we = 1'b0; cpu_ioreq = 1'b0;
        tick();
        check("io_no_cpu_write", 32'(cpu_data_in), 32'h40);

        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
